// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide unit
// Holds the md_op opcodes, the FSM state encoding and the divide-by-zero LO value.
package md_pkg;
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/md_core.sv
// md_core: combinational 64-bit {HI,LO} result from the latched operands
// Ports: a/b operands, is_div selects divide, sgn selects signed, res = {HI,LO}.
module md_core
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_div,
    input  logic        sgn,
    output logic [63:0] res
);
    logic        na, nb;
    logic [31:0] ma, mb, dv, q, r, qs, rs;
    logic [63:0] prod;
    // Divide on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign na   = sgn & a[31];
    assign nb   = sgn & b[31];
    assign ma   = na ? -a : a;
    assign mb   = nb ? -b : b;
    assign dv   = (mb == '0) ? 32'd1 : mb;
    assign q    = ma / dv;
    assign r    = ma % dv;
    assign qs   = (na ^ nb) ? -q : q;
    assign rs   = na ? -r : r;
    // Low 64 bits of the extended product are correct for both signednesses.
    assign prod = {{32{na}}, a} * {{32{nb}}, b};
    assign res  = !is_div ? prod : (b == '0) ? {a, DIV0_LO} : {rs, qs};
endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit holding the HI/LO registers
// Ports: clk, reset (async active-low), start/md_op/rs_val/rt_val issue an op;
// busy while an arithmetic op is in flight, done pulses when HI/LO are written,
// high/low are the architectural HI/LO registers.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] high,
    output logic [31:0] low
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state, nstate;
    logic [CW-1:0] cnt;
    logic [31:0] a, b;
    logic        sgn, idle, go_mul, go_div, fin;
    logic [63:0] res;

    assign idle   = (state == ST_IDLE);
    assign go_mul = start & idle & (md_op == MD_MULT || md_op == MD_MULTU);
    assign go_div = start & idle & (md_op == MD_DIV || md_op == MD_DIVU);
    assign fin    = !idle && cnt == '0;

    md_core u_core (
        .a      (a),
        .b      (b),
        .is_div (state == ST_DIV),
        .sgn    (sgn),
        .res    (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            sgn   <= 1'b0;
            done  <= 1'b0;
            high  <= '0;
            low   <= '0;
        end else begin
            state <= nstate;
            done  <= fin;
            if (go_mul || go_div) begin
                a   <= rs_val;
                b   <= rt_val;
                sgn <= (md_op == MD_MULT || md_op == MD_DIV);
                cnt <= go_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (fin) begin
                {high, low} <= res;
            end else if (start && idle && md_op == MD_MTHI) begin
                high <= rs_val;
            end else if (start && idle && md_op == MD_MTLO) begin
                low <= rs_val;
            end
        end
    end

    always_comb begin
        nstate = go_mul ? ST_MUL : go_div ? ST_DIV : fin ? ST_IDLE : state;
    end

    always_comb begin
        busy = !idle;
    end
endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 0, reset = 0, start = 0;
    logic [2:0]  md_op = 0;
    logic [31:0] rs_val = 0, rt_val = 0;
    logic        busy, done;
    logic [31:0] high, low;

    int tests = 0, fails = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
        .high(high), .low(low)
    );

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            3'd0: return 64'(sx * sy);
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pulse, hilo=%h", {high, low});
            end else begin
                chk("hilo", {high, low}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1; md_op = op; rs_val = x; rt_val = y;
        @(negedge clk);
        start = 0; md_op = 3'($urandom_range(0, 7));
        rs_val = $urandom; rt_val = $urandom;
    endtask

    // poke >= 0: keep start asserted with that op for the whole busy window.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int poke);
        int n = 0;
        exp_q.push_back(model(op, x, y));
        issue(op, x, y);
        while (busy && n < 50) begin
            if (poke >= 0) begin
                start = 1; md_op = 3'(poke); rs_val = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start = 0;
        chk("busy_cycles", 64'(n), (op < 2) ? 64'(MC) : 64'(DC));
    endtask

    initial begin
        logic [63:0] saved;
        repeat (2) @(negedge clk);
        chk("reset_hilo", {high, low}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1;

        run_op(0, 32'hFFFF_FFFE, 32'd3, -1);
        chk("mult_plan", {high, low}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(1, 32'hFFFF_FFFE, 32'd3, -1);
        chk("multu_plan", {high, low}, 64'h0000_0002_FFFF_FFFA);
        run_op(2, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_plan", {high, low}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3, 32'd7, 32'd2, -1);
        chk("divu_plan", {high, low}, 64'h0000_0001_0000_0003);
        run_op(3, 32'h1234, 32'd0, -1);
        chk("divu_zero", {high, low}, 64'h0000_1234_FFFF_FFFF);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("div_ovf", {high, low}, 64'h0000_0000_8000_0000);

        issue(4, 32'hDEAD_BEEF, 32'd0);
        chk("mthi", {31'd0, busy, high}, 64'h0000_0000_DEAD_BEEF);
        issue(5, 32'h0BAD_F00D, 32'd0);
        chk("mtlo", {high, low}, 64'hDEAD_BEEF_0BAD_F00D);

        run_op(2, 32'd100, 32'd7, 5);
        chk("mtlo_while_busy", {high, low}, 64'h0000_0002_0000_000E);

        saved = {high, low};
        issue(6, 32'h1111_1111, 32'd1);
        chk("reserved6", {31'd0, busy, high}, {32'd0, saved[63:32]});
        issue(7, 32'h2222_2222, 32'd1);
        chk("reserved7", {31'd0, busy, low}, {32'd0, saved[31:0]});

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] x, y;
            op = 3'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 9));
                3: y = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, x, y, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        exp_q.push_back(model(0, 32'd9, 32'd9));
        issue(0, 32'd9, 32'd9);
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        void'(exp_q.pop_back());
        chk("abort_hilo", {high, low}, 64'd0);
        chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1;
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("after_abort", {high, low}, 64'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
